wb_vic: RTL and testbench
=========================

// Module: wb_vic
// PURPOSE
//  Parametrised vectored interrupt controller; Wishbone slave in the peripheral window, drives the CPU interrupt request/vector/ack.
//  Generalises the 4-input controller: N channels, per-channel enable, edge/level mode, polarity, software trigger, programmable vector base.
//  Presents one arbitrated request; the vector is latched and held stable until the CPU acknowledges.
// PARAMETERS
//  N          8      number of interrupt channels, 1..32
//  SYNC       2      input synchroniser depth, >=2
//  VBASE_RST  8'h40  reset value of vector base register
//  SPUR_VEC   8'd24  vector returned on ack with no latched request
// PORTS
//  clk_i      in   1   single clock
//  rst_ni     in   1   asynchronous reset, active-low
//  cyc_i      in   1   Wishbone cycle
//  stb_i      in   1   Wishbone strobe (already decoded)
//  we_i       in   1   write enable
//  adr_i      in   3   word address
//  sel_i      in   4   byte selects
//  dat_i      in   32  write data
//  ack_o      out  1   Wishbone ack
//  dat_o      out  32  read data
//  irq_in     in   N   raw interrupt sources, asynchronous
//  irq_req    out  1   interrupt request to CPU
//  irq_vec    out  8   interrupt vector
//  irq_ack    in   1   one-cycle CPU acknowledge pulse
// BEHAVIOUR
//  Reset: ack_o=0, dat_o=0, irq_req=0, irq_vec=SPUR_VEC, all regs 0 except VBASE=VBASE_RST, state IDLE.
//  Registers (adr_i; bits >=N read 0, ignore writes; sel_i honoured per byte on RW regs):
//   0 PEND  R: pending; W1C clears edge-mode bits only
//   1 EN    RW enable mask
//   2 MODE  RW 1=edge, 0=level
//   3 POL   RW 1=active-low source
//   4 INSV  R: {valid, 23'b0, latched vector}
//   5 VBASE RW [7:0]
//   6 SWI   W: 1 sets pending (edge semantics regardless of MODE)
//   7 -     reads 0
//  Bus: ack_o asserted one cycle after cyc_i&stb_i&!ack_o, for one cycle; dat_o valid with ack_o; write takes effect on ack cycle.
//  Input path: src = irq_in ^ POL, through SYNC flops; edge = rising edge of synchronised src.
//  Pending: edge mode: set on edge or SWI, held until W1C or ack of that channel; level mode: pend = synced src | SWI-latched bit.
//  Set beats clear in the same cycle (edge/SWI vs W1C or ack clear).
//  Eligible = PEND & EN; winner = lowest-index eligible channel (fixed priority, channel 0 highest).
//  FSM: IDLE: eligible!=0 -> latch idx, irq_vec=VBASE+idx (8-bit wrap), irq_req=1 -> REQ.
//   REQ: irq_ack -> clear PEND[idx] if edge mode, irq_req=0, irq_vec held -> GAP.
//        latched channel no longer eligible, no ack -> irq_req=0, irq_vec=SPUR_VEC -> IDLE.
//        Higher-priority arrival in REQ does NOT re-latch; served after GAP.
//   GAP: one cycle irq_req=0 -> IDLE (guarantees CPU sees fresh edge).
//  irq_ack in IDLE/GAP: irq_vec=SPUR_VEC, no state change.
//  Latency: synced edge to irq_req = 2 cycles (pend reg + FSM) after sync chain.
//  VBASE write while in REQ does not change held irq_vec.
//  Reset mid-operation: all state cleared immediately; synchroniser flops cleared to 0 (edge on source already high after reset is not generated; level source pends).
// STRUCTURE
//  Package wb_vic_pkg: register offset constants, FSM state enum {IDLE,REQ,GAP}, SPUR default.
//  Sub-module vic_sync_edge: per-channel SYNC-deep synchroniser + rising edge detect, instantiated N times via generate.
//  Priority encoder as function in the package; everything else in wb_vic.
// TESTING
//  Reset: rst_ni=0 mid-REQ -> irq_req=0, irq_vec=8'd24, VBASE reads 8'h40 after release.
//  Edge ch3, EN=0x08, MODE=0x08: pulse irq_in[3] -> irq_req, irq_vec=8'h43; irq_ack -> PEND=0, irq_req low 1 cycle.
//  Priority: ch5 and ch1 edge same cycle -> vec 8'h41 first, after ack+GAP vec 8'h45.
//  Level ch2 POL=1: hold irq_in[2]=0 -> repeated requests after each ack until input released; W1C on PEND[2] no effect.
//  Withdrawal: latch ch4, write EN=0 before ack -> irq_req drops, irq_vec=8'd24; late irq_ack returns 8'd24.
//  SWI write 0x80 with N=8, VBASE=8'hF0 -> vec 8'hF7; SWI same cycle as W1C bit7 -> bit7 stays pending.

Source files
------------

// File: rtl/wb_vic_pkg.sv
// Shared definitions for the wb_vic vectored interrupt controller:
// register map, controller states and the fixed-priority encoder.
package wb_vic_pkg;

    localparam logic [2:0] ADR_PEND  = 3'd0;
    localparam logic [2:0] ADR_EN    = 3'd1;
    localparam logic [2:0] ADR_MODE  = 3'd2;
    localparam logic [2:0] ADR_POL   = 3'd3;
    localparam logic [2:0] ADR_INSV  = 3'd4;
    localparam logic [2:0] ADR_VBASE = 3'd5;
    localparam logic [2:0] ADR_SWI   = 3'd6;

    localparam logic [7:0] SPUR_DEFAULT  = 8'd24;
    localparam logic [7:0] VBASE_DEFAULT = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } vic_state_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } prio_t;

    // Lowest set bit wins; scanning downwards lets the last hit be the lowest index.
    function automatic prio_t prio_enc(input logic [31:0] req);
        prio_t res;
        res.found = 1'b0;
        res.idx   = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            res.found = req[i] ? 1'b1 : res.found;
            res.idx   = req[i] ? i[4:0] : res.idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/vic_sync_edge.sv
// One interrupt channel front end: multi-flop synchroniser plus rising-edge detect.
// Edges are suppressed until the chain holds real samples, so a source already high at reset release does not fire.
module vic_sync_edge #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic synced,
    output logic rise
);

    logic [SYNC-1:0] sync_r;
    logic            prev_r;
    logic [SYNC:0]   vld_r;

    // Synchroniser chain, previous-sample flop and sample-valid tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
            vld_r  <= '0;
        end else begin
            sync_r <= {sync_r[SYNC-2:0], src};
            prev_r <= sync_r[SYNC-1];
            vld_r  <= {vld_r[SYNC-1:0], 1'b1};
        end
    end

    assign synced = sync_r[SYNC-1];
    assign rise   = sync_r[SYNC-1] & ~prev_r & vld_r[SYNC];

endmodule

// File: rtl/wb_vic.sv
// Parametrised vectored interrupt controller with a Wishbone register window.
// One arbitrated request is presented; its vector stays latched until the CPU acknowledges.
module wb_vic
    import wb_vic_pkg::*;
#(
    parameter int          N         = 8,
    parameter int          SYNC      = 2,
    parameter logic [7:0]  VBASE_RST = VBASE_DEFAULT,
    parameter logic [7:0]  SPUR_VEC  = SPUR_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic [2:0]    adr_i,
    input  logic [3:0]    sel_i,
    input  logic [31:0]   dat_i,
    output logic          ack_o,
    output logic [31:0]   dat_o,
    input  logic [N-1:0]  irq_in,
    output logic          irq_req,
    output logic [7:0]    irq_vec,
    input  logic          irq_ack
);

    logic [N-1:0]  en_r, mode_r, pol_r, sticky_r;
    logic [7:0]    vbase_r, vec_r;
    logic [4:0]    idx_r;
    logic          req_r, ack_r;
    logic [31:0]   dat_r;
    vic_state_t    state_r;

    logic [N-1:0]  synced_s, rise_s, pend_s, elig_s, w1c_s, swi_s, ack_clr_s, wdat_n_s, wm_n_s;
    logic [31:0]   wmask_s, wdat_s, rd_s, elig32_s, ack_clr32_s;
    logic          bus_req_s, wr_s, unused_s;
    prio_t         prio_s;

    for (genvar g = 0; g < N; g++) begin : g_ch
        vic_sync_edge #(.SYNC(SYNC)) u_sync (
            .clk    (clk_i),
            .rst_n  (rst_ni),
            .src    (irq_in[g] ^ pol_r[g]),
            .synced (synced_s[g]),
            .rise   (rise_s[g])
        );
    end

    assign bus_req_s = cyc_i & stb_i;
    assign wr_s      = bus_req_s & we_i & ack_r;
    assign wmask_s   = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign wdat_s    = dat_i & wmask_s;
    assign wdat_n_s  = wdat_s[N-1:0];
    assign wm_n_s    = wmask_s[N-1:0];

    // Level channels follow the synchronised source; the sticky part holds edges and software triggers.
    assign pend_s = sticky_r | (~mode_r & synced_s);
    assign elig_s = pend_s & en_r;
    assign prio_s = prio_enc(elig32_s);
    assign ack_clr32_s = (state_r == ST_REQ && irq_ack) ? (32'd1 << idx_r) : 32'd0;
    assign ack_clr_s   = ack_clr32_s[N-1:0];
    assign unused_s    = ^{wdat_s, wmask_s, ack_clr32_s};

    // Zero-extend eligibility, and decode write-one-to-clear / software-trigger strobes.
    always_comb begin
        elig32_s         = 32'd0;
        elig32_s[N-1:0]  = elig_s;
        w1c_s            = '0;
        swi_s            = '0;
        if (wr_s && adr_i == ADR_PEND) begin
            w1c_s = wdat_n_s;
        end else if (wr_s && adr_i == ADR_SWI) begin
            swi_s = wdat_n_s;
        end else begin
            w1c_s = '0;
            swi_s = '0;
        end
    end

    // Register read multiplexer; bits above N read as zero.
    always_comb begin
        rd_s = 32'd0;
        case (adr_i)
            ADR_PEND:  rd_s[N-1:0] = pend_s;
            ADR_EN:    rd_s[N-1:0] = en_r;
            ADR_MODE:  rd_s[N-1:0] = mode_r;
            ADR_POL:   rd_s[N-1:0] = pol_r;
            ADR_INSV:  rd_s        = {(state_r == ST_REQ), 23'd0, vec_r};
            ADR_VBASE: rd_s[7:0]   = vbase_r;
            default:   rd_s        = 32'd0;
        endcase
    end

    // Wishbone handshake: single-cycle ack one cycle after the strobe, data registered with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= bus_req_s & ~ack_r;
            dat_r <= (bus_req_s & ~ack_r) ? rd_s : 32'd0;
        end
    end

    // Configuration registers, written on the ack cycle with byte selects honoured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_r    <= '0;
            mode_r  <= '0;
            pol_r   <= '0;
            vbase_r <= VBASE_RST;
        end else if (wr_s) begin
            case (adr_i)
                ADR_EN:    en_r    <= (en_r   & ~wm_n_s) | wdat_n_s;
                ADR_MODE:  mode_r  <= (mode_r & ~wm_n_s) | wdat_n_s;
                ADR_POL:   pol_r   <= (pol_r  & ~wm_n_s) | wdat_n_s;
                ADR_VBASE: vbase_r <= (vbase_r & ~wmask_s[7:0]) | wdat_s[7:0];
                default:   ;
            endcase
        end
    end

    // Sticky pending bits; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_r <= '0;
        end else begin
            sticky_r <= (sticky_r & ~(w1c_s | ack_clr_s)) | (mode_r & rise_s) | swi_s;
        end
    end

    // Request controller: latch the winner, hold its vector until ack, then force one idle gap cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            vec_r   <= SPUR_VEC;
            idx_r   <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (irq_ack) begin
                        vec_r <= SPUR_VEC;
                    end else if (prio_s.found) begin
                        idx_r   <= prio_s.idx;
                        vec_r   <= vbase_r + {3'b000, prio_s.idx};
                        req_r   <= 1'b1;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        req_r   <= 1'b0;
                        state_r <= ST_GAP;
                    end else if (!elig32_s[idx_r]) begin
                        req_r   <= 1'b0;
                        vec_r   <= SPUR_VEC;
                        state_r <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (irq_ack) begin
                        vec_r <= SPUR_VEC;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    vec_r   <= SPUR_VEC;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o   = ack_r;
    assign dat_o   = dat_r;
    assign irq_req = req_r;
    assign irq_vec = vec_r;

endmodule

// File: tb/tb_wb_vic.sv
// Directed and randomized bench for wb_vic (N=8, SYNC=2, VBASE reset 8'h40, spurious vector 8'd24).
module tb_wb_vic;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [7:0]  irq_in;
    logic        irq_req;
    logic [7:0]  irq_vec;
    logic        irq_ack;

    int n_assert = 0;
    int n_fail   = 0;

    wb_vic dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .we_i    (we),
        .adr_i   (adr),
        .sel_i   (sel),
        .dat_i   (dat_w),
        .ack_o   (ack),
        .dat_o   (dat_r),
        .irq_in  (irq_in),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic w, input logic [2:0] a, input logic [31:0] d,
                            input logic with_irq_ack, output logic [31:0] rd);
        int waited;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = 4'hF;
        waited = 0;
        while (!ack && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("wb_ack", {31'd0, ack}, 32'd1);
        rd = dat_r;
        if (with_irq_ack) irq_ack = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; irq_ack = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_cycle(1'b1, a, d, 1'b0, dummy);
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_cycle(1'b0, a, 32'd0, 1'b0, rd);
        check(tag, rd, exp);
    endtask

    task automatic wait_req(input string tag, input logic [7:0] exp_vec);
        int waited = 0;
        while (!irq_req && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check(tag, {31'd0, irq_req}, 32'd1);
        check({tag, "_vec"}, {24'd0, irq_vec}, {24'd0, exp_vec});
    endtask

    // CPU acknowledge: request drops with the vector held, and stays low through the gap cycle.
    task automatic pulse_ack(input string tag, input logic [7:0] exp_vec);
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check({tag, "_ack_req"}, {31'd0, irq_req}, 32'd0);
        check({tag, "_ack_vec"}, {24'd0, irq_vec}, {24'd0, exp_vec});
        @(negedge clk);
        check({tag, "_gap_req"}, {31'd0, irq_req}, 32'd0);
    endtask

    task automatic pulse_in(input logic [7:0] mask);
        @(negedge clk);
        irq_in = irq_in | mask;
        repeat (3) @(negedge clk);
        irq_in = irq_in & ~mask;
    endtask

    logic [31:0] rd;
    logic [7:0]  vbase, en, mask, rem;
    int          lo, waited;

    initial begin
        rst_ni = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 3'd0; sel = 4'h0;
        dat_w = 32'd0; irq_in = 8'd0; irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, irq_req}, 32'd0);
        check("rst_vec", {24'd0, irq_vec}, 32'd24);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_r, 32'd0);
        rst_ni = 1'b1;
        read_check("rst_vbase", 3'd5, 32'h40);
        read_check("rst_en", 3'd1, 32'h0);
        read_check("rst_pend", 3'd0, 32'h0);
        read_check("rst_insv", 3'd4, 32'h18);
        read_check("rst_adr7", 3'd7, 32'h0);

        // Edge channel 3
        wb_write(3'd1, 32'h08);
        wb_write(3'd2, 32'h08);
        read_check("mode_rb", 3'd2, 32'h08);
        pulse_in(8'h08);
        wait_req("ch3", 8'h43);
        read_check("ch3_insv", 3'd4, 32'h8000_0043);
        read_check("ch3_pend", 3'd0, 32'h08);
        pulse_ack("ch3", 8'h43);
        read_check("ch3_pend_clr", 3'd0, 32'h0);
        check("ch3_no_rereq", {31'd0, irq_req}, 32'd0);
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        check("idle_ack_vec", {24'd0, irq_vec}, 32'd24);

        // Priority: channels 5 and 1 together
        wb_write(3'd1, 32'h22);
        wb_write(3'd2, 32'h22);
        pulse_in(8'h22);
        wait_req("prio_first", 8'h41);
        pulse_ack("prio_first", 8'h41);
        wait_req("prio_second", 8'h45);
        pulse_ack("prio_second", 8'h45);
        read_check("prio_pend", 3'd0, 32'h0);

        // Level channel 2, active-low
        wb_write(3'd1, 32'h00);
        irq_in[2] = 1'b1;
        wb_write(3'd3, 32'h04);
        wb_write(3'd2, 32'h00);
        wb_write(3'd1, 32'h04);
        irq_in[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_req("lvl", 8'h42);
            pulse_ack("lvl", 8'h42);
        end
        wait_req("lvl_last", 8'h42);
        wb_write(3'd0, 32'h04);
        read_check("lvl_w1c", 3'd0, 32'h04);
        check("lvl_w1c_req", {31'd0, irq_req}, 32'd1);
        irq_in[2] = 1'b1;
        waited = 0;
        while (irq_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("lvl_release_req", {31'd0, irq_req}, 32'd0);
        check("lvl_release_vec", {24'd0, irq_vec}, 32'd24);
        read_check("lvl_release_pend", 3'd0, 32'h0);
        wb_write(3'd1, 32'h00);
        irq_in[2] = 1'b0;
        wb_write(3'd3, 32'h00);

        // Withdrawal of channel 4
        wb_write(3'd1, 32'h10);
        wb_write(3'd2, 32'h10);
        pulse_in(8'h10);
        wait_req("wd", 8'h44);
        wb_write(3'd1, 32'h00);
        @(negedge clk);
        check("wd_req", {31'd0, irq_req}, 32'd0);
        check("wd_vec", {24'd0, irq_vec}, 32'd24);
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        check("wd_late_ack_vec", {24'd0, irq_vec}, 32'd24);
        read_check("wd_pend_held", 3'd0, 32'h10);
        wb_write(3'd0, 32'h10);
        read_check("wd_pend_w1c", 3'd0, 32'h0);

        // Software trigger on channel 7, level mode
        wb_write(3'd5, 32'hF0);
        wb_write(3'd2, 32'h00);
        wb_write(3'd1, 32'h80);
        wb_write(3'd6, 32'h80);
        wait_req("swi", 8'hF7);
        read_check("swi_pend", 3'd0, 32'h80);
        wb_write(3'd5, 32'h10);
        check("swi_vec_hold", {24'd0, irq_vec}, 32'hF7);
        read_check("swi_insv", 3'd4, 32'h8000_00F7);
        wb_cycle(1'b1, 3'd6, 32'h80, 1'b1, rd);
        check("swi_ack_req", {31'd0, irq_req}, 32'd0);
        wait_req("swi_again", 8'h17);
        read_check("swi_set_wins", 3'd0, 32'h80);
        pulse_ack("swi_again", 8'h17);
        read_check("swi_pend_clr", 3'd0, 32'h0);

        // Randomized rounds against a simple pending-set model
        vbase = 8'($urandom_range(0, 255));
        wb_write(3'd5, {24'd0, vbase});
        wb_write(3'd2, 32'hFF);
        for (int r = 0; r < 12; r++) begin
            en   = 8'($urandom_range(0, 255));
            mask = 8'($urandom_range(1, 255));
            wb_write(3'd1, {24'd0, en});
            pulse_in(mask);
            repeat (6) @(negedge clk);
            read_check("rnd_pend", 3'd0, {24'd0, mask});
            rem = mask & en;
            while (rem != 8'd0) begin
                lo = 0;
                for (int i = 7; i >= 0; i--) if (rem[i]) lo = i;
                wait_req("rnd", 8'(vbase + 8'(lo)));
                pulse_ack("rnd", 8'(vbase + 8'(lo)));
                rem[lo] = 1'b0;
            end
            repeat (6) @(negedge clk);
            check("rnd_idle", {31'd0, irq_req}, 32'd0);
            read_check("rnd_left", 3'd0, {24'd0, mask & ~en});
            wb_write(3'd0, 32'hFF);
        end

        // Reset in the middle of a request
        wb_write(3'd1, 32'h01);
        wb_write(3'd6, 32'h01);
        wait_req("pre_rst", vbase);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("midrst_req", {31'd0, irq_req}, 32'd0);
        check("midrst_vec", {24'd0, irq_vec}, 32'd24);
        @(negedge clk);
        rst_ni = 1'b1;
        read_check("midrst_vbase", 3'd5, 32'h40);
        read_check("midrst_en", 3'd1, 32'h0);
        read_check("midrst_pend", 3'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
